// File: rtl/stack_cmd_pkg.sv
// rtl/stack_cmd_pkg.sv - op encodings, FSM states and size defaults for the stack command controller.
// ST_PK_WB exists only when STACK_CMD_CTRL_PEEK_EN is defined.
package stack_cmd_pkg;

  localparam int DATA_W_DEF = 4;
  localparam int DEPTH_DEF  = 16;

  typedef enum logic [1:0] {
    OP_PUSH = 2'b00,
    OP_CALL = 2'b01,
    OP_POP  = 2'b10,
    OP_PEEK = 2'b11
  } op_t;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_PUSH    = 3'd1,
    ST_POP_DEC = 3'd2,
    ST_POP_RD  = 3'd3,
    ST_RESP    = 3'd4
`ifdef STACK_CMD_CTRL_PEEK_EN
    ,
    ST_PK_WB   = 3'd5
`endif
  } state_t;

endpackage

// File: rtl/stack_rsp_slot.sv
// rtl/stack_rsp_slot.sv - single-entry response holding register.
// Loaded by the controller and cleared when the consumer takes it.
module stack_rsp_slot #(
  parameter int DATA_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [DATA_W-1:0] load_data,
  input  logic              load_err,
  input  logic              rsp_ready,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_err
);

  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_err   <= 1'b0;
    end else if (load) begin
      rsp_valid <= 1'b1;
      rsp_data  <= load_data;
      rsp_err   <= load_err;
    end else if (rsp_valid && rsp_ready) begin
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_err   <= 1'b0;
    end
  end

endmodule

// File: rtl/stack_cmd_ctrl.sv
// rtl/stack_cmd_ctrl.sv - command-side sequencer for the LIFO stack, one command in flight.
// STACK_CMD_CTRL_PEEK_EN enables op 11 as PEEK; otherwise op 11 returns an error.
module stack_cmd_ctrl
  import stack_cmd_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [DATA_W-1:0] cmd_data,
  input  logic [DATA_W-1:0] cmd_pc,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_err,
  output logic              stk_reset,
  output logic              stk_push,
  output logic              stk_pop,
  output logic              stk_we,
  output logic              stk_re,
  output logic              stk_mux_sel,
  output logic [DATA_W-1:0] stk_data_a,
  output logic [DATA_W-1:0] stk_data_b,
  input  logic [DATA_W-1:0] stk_dout,
  input  logic              stk_full,
  input  logic              stk_empty
);

  state_t            state;
  op_t               op_q;
  logic [DATA_W-1:0] data_q;
  logic [DATA_W-1:0] pc_q;
  logic              accept;
  logic              is_push_op;
  logic              idle_err;
  logic              load;
  logic [DATA_W-1:0] load_data;
  logic              load_err;

  assign cmd_ready  = (state == ST_IDLE) && !rst;
  assign accept     = cmd_valid && cmd_ready;
  assign stk_reset  = rst;
  assign stk_data_a = data_q;
  assign stk_data_b = pc_q;
  assign is_push_op = (cmd_op == OP_PUSH) || (cmd_op == OP_CALL);

  // Flags are judged only here so the stack is never driven past full/empty.
  always_comb begin
    idle_err = 1'b0;
    case (cmd_op)
      OP_PUSH, OP_CALL: idle_err = stk_full;
      OP_POP:           idle_err = stk_empty;
`ifdef STACK_CMD_CTRL_PEEK_EN
      default:          idle_err = stk_empty;
`else
      default:          idle_err = 1'b1;
`endif
    endcase
  end

  always_comb begin
    load      = 1'b0;
    load_data = '0;
    load_err  = 1'b0;
    case (state)
      ST_IDLE: begin
        load     = accept && idle_err;
        load_err = accept && idle_err;
      end
      ST_PUSH: load = 1'b1;
      ST_POP_RD: begin
        if (op_q == OP_POP) begin
          load      = 1'b1;
          load_data = stk_dout;
        end
      end
`ifdef STACK_CMD_CTRL_PEEK_EN
      ST_PK_WB: begin
        load      = 1'b1;
        load_data = data_q;
      end
`endif
      default: ;
    endcase
  end

  // Stack controls are registered alongside the state they belong to.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      op_q        <= OP_PUSH;
      data_q      <= '0;
      pc_q        <= '0;
      stk_push    <= 1'b0;
      stk_pop     <= 1'b0;
      stk_we      <= 1'b0;
      stk_re      <= 1'b0;
      stk_mux_sel <= 1'b0;
    end else begin
      stk_push    <= 1'b0;
      stk_pop     <= 1'b0;
      stk_we      <= 1'b0;
      stk_re      <= 1'b0;
      stk_mux_sel <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            op_q   <= op_t'(cmd_op);
            data_q <= cmd_data;
            pc_q   <= cmd_pc;
            if (idle_err) begin
              state <= ST_RESP;
            end else if (is_push_op) begin
              state       <= ST_PUSH;
              stk_we      <= 1'b1;
              stk_push    <= 1'b1;
              stk_mux_sel <= (cmd_op == OP_PUSH);
            end else begin
              state   <= ST_POP_DEC;
              stk_pop <= 1'b1;
            end
          end
        end
        ST_PUSH: state <= ST_RESP;
        ST_POP_DEC: begin
          state  <= ST_POP_RD;
          stk_re <= 1'b1;
        end
        ST_POP_RD: begin
`ifdef STACK_CMD_CTRL_PEEK_EN
          if (op_q == OP_PEEK) begin
            state       <= ST_PK_WB;
            data_q      <= stk_dout;
            stk_we      <= 1'b1;
            stk_push    <= 1'b1;
            stk_mux_sel <= 1'b1;
          end else begin
            state <= ST_RESP;
          end
`else
          state <= ST_RESP;
`endif
        end
`ifdef STACK_CMD_CTRL_PEEK_EN
        ST_PK_WB: state <= ST_RESP;
`endif
        ST_RESP: if (rsp_ready) state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  stack_rsp_slot #(.DATA_W(DATA_W)) u_rsp_slot (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
    .load_data (load_data),
    .load_err  (load_err),
    .rsp_ready (rsp_ready),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .rsp_err   (rsp_err)
  );

endmodule

// File: tb/tb_stack_cmd_ctrl.sv
// tb/tb_stack_cmd_ctrl.sv - scoreboard bench for stack_cmd_ctrl with a behavioural 16-entry stack.
module tb_stack_cmd_ctrl;

  localparam logic [1:0] P_PUSH = 2'b00;
  localparam logic [1:0] P_CALL = 2'b01;
  localparam logic [1:0] P_POP  = 2'b10;
  localparam logic [1:0] P_PEEK = 2'b11;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [1:0] cmd_op = 2'b00;
  logic [3:0] cmd_data = 4'h0;
  logic [3:0] cmd_pc = 4'h0;
  logic       rsp_valid;
  logic       rsp_ready = 1'b1;
  logic [3:0] rsp_data;
  logic       rsp_err;
  logic       stk_reset, stk_push, stk_pop, stk_we, stk_re, stk_mux_sel;
  logic [3:0] stk_data_a, stk_data_b, stk_dout;
  logic       stk_full, stk_empty;

  always #5 clk = ~clk;

  stack_cmd_ctrl dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_data(cmd_data), .cmd_pc(cmd_pc),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .stk_reset(stk_reset), .stk_push(stk_push), .stk_pop(stk_pop), .stk_we(stk_we),
    .stk_re(stk_re), .stk_mux_sel(stk_mux_sel), .stk_data_a(stk_data_a),
    .stk_data_b(stk_data_b), .stk_dout(stk_dout), .stk_full(stk_full), .stk_empty(stk_empty)
  );

  // Behavioural stack: write at pointer and increment together, pop decrements.
  logic [3:0] mem [16];
  logic [4:0] ptr;
  int we_cnt = 0;
  int pop_cnt = 0;

  always @(posedge clk) begin
    if (stk_we) we_cnt++;
    if (stk_pop) pop_cnt++;
    if (stk_reset) ptr <= 5'd0;
    else if (stk_we && stk_push && ptr < 5'd16) begin
      mem[ptr[3:0]] <= stk_mux_sel ? stk_data_a : stk_data_b;
      ptr <= ptr + 5'd1;
    end else if (stk_pop && ptr > 5'd0) ptr <= ptr - 5'd1;
  end

  assign stk_full  = (ptr == 5'd16);
  assign stk_empty = (ptr == 5'd0);
  assign stk_dout  = stk_re ? mem[ptr[3:0]] : 4'h0;

  typedef struct packed {
    logic [3:0] data;
    logic       err;
  } rsp_t;

  rsp_t exp_q[$];
  rsp_t exp_e;
  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) chk("rsp_unexpected", 1, 0);
      else begin
        exp_e = exp_q.pop_front();
        chk("rsp_data", {28'd0, rsp_data}, {28'd0, exp_e.data});
        chk("rsp_err", {31'd0, rsp_err}, {31'd0, exp_e.err});
      end
    end
  end

  task automatic wait_idle(input string nm);
    int n;
    n = 0;
    @(negedge clk);
    while (!cmd_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_ready) chk({nm, "_idle_timeout"}, 0, 1);
  endtask

  task automatic send(input logic [1:0] op, input logic [3:0] d, input logic [3:0] pc,
                      input logic [3:0] ed, input logic ee, input int lat, input string nm);
    int n;
    wait_idle(nm);
    if (!cmd_ready) return;
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_data  = d;
    cmd_pc    = pc;
    exp_q.push_back({ed, ee});
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    n = 1;
    @(negedge clk);
    while (!rsp_valid && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk({nm, "_latency"}, n, lat);
  endtask

  int we_before, pop_before;

  initial begin
    // 1: reset state, then push/call/pop/pop
    repeat (3) @(negedge clk);
    chk("reset_rsp_valid", {31'd0, rsp_valid}, 0);
    chk("reset_rsp_data", {28'd0, rsp_data}, 0);
    chk("reset_rsp_err", {31'd0, rsp_err}, 0);
    chk("reset_stk_ctrl", {27'd0, stk_push, stk_pop, stk_we, stk_re, stk_mux_sel}, 0);
    chk("reset_stk_reset", {31'd0, stk_reset}, 1);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_cmd_ready", {31'd0, cmd_ready}, 1);

    send(P_PUSH, 4'hA, 4'h0, 4'h0, 1'b0, 2, "t1_push");
    send(P_CALL, 4'h0, 4'h3, 4'h0, 1'b0, 2, "t1_call");
    send(P_POP, 4'h0, 4'h0, 4'h3, 1'b0, 3, "t1_pop1");
    send(P_POP, 4'h0, 4'h0, 4'hA, 1'b0, 3, "t1_pop2");
    wait_idle("t1");
    chk("t1_empty", {31'd0, stk_empty}, 1);

    // 3: pop on empty
    pop_before = pop_cnt;
    send(P_POP, 4'h0, 4'h0, 4'h0, 1'b1, 1, "t3_underflow");
    wait_idle("t3");
    chk("t3_no_pop", pop_cnt, pop_before);

    // 5: peek after push 7
    send(P_PUSH, 4'h7, 4'h0, 4'h0, 1'b0, 2, "t5_push");
`ifdef STACK_CMD_CTRL_PEEK_EN
    send(P_PEEK, 4'h0, 4'h0, 4'h7, 1'b0, 4, "t5_peek");
`else
    send(P_PEEK, 4'h0, 4'h0, 4'h0, 1'b1, 1, "t5_peek");
`endif
    send(P_POP, 4'h0, 4'h0, 4'h7, 1'b0, 3, "t5_pop");
    wait_idle("t5");
    chk("t5_empty", {31'd0, stk_empty}, 1);

    // 4: response back-pressure
    send(P_PUSH, 4'h9, 4'h0, 4'h0, 1'b0, 2, "t4_push");
    wait_idle("t4a");
    rsp_ready = 1'b0;
    send(P_POP, 4'h0, 4'h0, 4'h9, 1'b0, 3, "t4_pop");
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t4_hold_valid", {31'd0, rsp_valid}, 1);
      chk("t4_hold_data", {28'd0, rsp_data}, 32'h9);
      chk("t4_hold_ready", {31'd0, cmd_ready}, 0);
    end
    @(posedge clk);
    #1 rsp_ready = 1'b1;
    wait_idle("t4b");
    chk("t4_queue_drained", exp_q.size(), 0);

    // 2: fill, overflow, pop top
    for (int i = 0; i < 16; i++) send(P_PUSH, 4'(i), 4'h0, 4'h0, 1'b0, 2, "t2_fill");
    wait_idle("t2a");
    chk("t2_full", {31'd0, stk_full}, 1);
    we_before = we_cnt;
    send(P_PUSH, 4'h5, 4'h0, 4'h0, 1'b1, 1, "t2_overflow");
    wait_idle("t2b");
    chk("t2_no_we", we_cnt, we_before);
    send(P_POP, 4'h0, 4'h0, 4'hF, 1'b0, 3, "t2_pop");

    // 6: reset while in POP_RD
    wait_idle("t6a");
    cmd_valid = 1'b1;
    cmd_op    = P_POP;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("t6_in_pop_rd", {31'd0, stk_re}, 1);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("t6_rsp_valid", {31'd0, rsp_valid}, 0);
    chk("t6_empty", {31'd0, stk_empty}, 1);
    chk("t6_ready", {31'd0, cmd_ready}, 1);
    send(P_PUSH, 4'h2, 4'h0, 4'h0, 1'b0, 2, "t6_push");
    send(P_POP, 4'h0, 4'h0, 4'h2, 1'b0, 3, "t6_pop");
    wait_idle("t6b");
    chk("final_queue_drained", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired actual=running required=finished");
    $fatal(1, "watchdog");
  end

endmodule
